muldiv_ctrl: RTL and testbench

//  Sequencing controller for the shared multiply/divide unit of the RV32IM core.

---
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_ctrl.sv | 146 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: decoder/writeback handshake bundle for the shared multiply/divide unit.
// master = issuing pipeline side, slave = muldiv_ctrl.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            mul_en;
  logic            mul_operation;
  logic            div_en;
  logic            div_operation;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_sel;
  logic            flush;
  logic            wb_ready;
  logic            stall;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;
  logic            result_valid;

  modport master (
    output mul_en, mul_operation, div_en, div_operation, op_a, op_b, rd_sel, flush, wb_ready,
    input  stall, result, result_rd, result_valid
  );

  modport slave (
    input  mul_en, mul_operation, div_en, div_operation, op_a, op_b, rd_sel, flush, wb_ready,
    output stall, result, result_rd, result_valid
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MUL/MULH and 32-step restoring DIV/REM sequencer for RV32IM.
// Define MULDIV_DIVREM_FUSE_EN to reuse the last normal division for a matching DIV/REM.
module muldiv_ctrl #(
  parameter int MUL_LATENCY = 2,
  parameter int XLEN        = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

`ifdef MULDIV_DIVREM_FUSE_EN
  localparam bit FUSE_EN = 1'b1;
`else
  localparam bit FUSE_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t          state;
  logic [4:0]      cnt;
  logic            op_sel;
  logic [XLEN-1:0] a_r, b_r, quo, rem;
  logic [XLEN-1:0] result, c_a, c_b, c_q, c_r;
  logic [4:0]      result_rd;
  logic            result_valid, c_vld;

  function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
    return c ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return neg_if(v[XLEN-1], v);
  endfunction

  logic                   req;
  logic signed [2*XLEN-1:0] product;
  logic [XLEN-1:0]        dmag, q_fix, r_fix;
  logic [XLEN:0]          rem_shift, diff;
  logic                   first, div_zero, div_ovf, cache_hit;

  assign req       = (bus.mul_en | bus.div_en) & ~bus.flush;
  assign product   = $signed({{XLEN{a_r[XLEN-1]}}, a_r}) * $signed({{XLEN{b_r[XLEN-1]}}, b_r});
  assign dmag      = mag(b_r);
  assign rem_shift = {rem, quo[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dmag};
  assign q_fix     = neg_if(a_r[XLEN-1] ^ b_r[XLEN-1], quo);
  assign r_fix     = neg_if(a_r[XLEN-1], rem);
  assign first     = (cnt == 5'd0);
  assign div_zero  = (b_r == '0);
  assign div_ovf   = (a_r == MIN_INT) && (b_r == '1);
  assign cache_hit = FUSE_EN && c_vld && (a_r == c_a) && (b_r == c_b);

  assign bus.stall        = ((state == IDLE) & req) |
                            ((state != IDLE) & ~((state == DONE) & bus.wb_ready));
  assign bus.result       = result;
  assign bus.result_rd    = result_rd;
  assign bus.result_valid = result_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_sel       <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      quo          <= '0;
      rem          <= '0;
      result       <= '0;
      result_rd    <= '0;
      result_valid <= 1'b0;
      c_a          <= '0;
      c_b          <= '0;
      c_q          <= '0;
      c_r          <= '0;
      c_vld        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          a_r       <= bus.op_a;
          b_r       <= bus.op_b;
          result_rd <= bus.rd_sel;
          op_sel    <= bus.mul_en ? bus.mul_operation : bus.div_operation;
          quo       <= mag(bus.op_a);
          rem       <= '0;
          cnt       <= '0;
          state     <= bus.mul_en ? MUL : DIV;
        end
        MUL: if (bus.flush) begin
          state <= IDLE;
        end else if (cnt == 5'(MUL_LATENCY - 1)) begin
          result       <= op_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
          result_valid <= 1'b1;
          state        <= DONE;
        end else begin
          cnt <= cnt + 5'd1;
        end
        // DIV: first cycle resolves special cases / cache hits, otherwise one quotient bit per cycle
        DIV: if (bus.flush) begin
          state <= IDLE;
          c_vld <= 1'b0;
        end else if (first && div_zero) begin
          result       <= op_sel ? '1 : a_r;
          result_valid <= 1'b1;
          state        <= DONE;
        end else if (first && div_ovf) begin
          result       <= op_sel ? MIN_INT : '0;
          result_valid <= 1'b1;
          state        <= DONE;
        end else if (first && cache_hit) begin
          result       <= op_sel ? c_q : c_r;
          result_valid <= 1'b1;
          state        <= DONE;
        end else begin
          quo <= {quo[XLEN-2:0], ~diff[XLEN]};
          rem <= diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
          if (cnt == 5'd31) state <= FIX;
          else              cnt   <= cnt + 5'd1;
        end
        FIX: if (bus.flush) begin
          state <= IDLE;
          c_vld <= 1'b0;
        end else begin
          result       <= op_sel ? q_fix : r_fix;
          result_valid <= 1'b1;
          state        <= DONE;
          if (FUSE_EN) begin
            c_a   <= a_r;
            c_b   <= b_r;
            c_q   <= q_fix;
            c_r   <= r_fix;
            c_vld <= 1'b1;
          end
        end
        DONE: if (bus.flush || bus.wb_ready) begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with hand-computed results for muldiv_ctrl (MUL_LATENCY=2).
// Expected division latencies follow MULDIV_DIVREM_FUSE_EN when the bench is built with it.
module tb_muldiv_ctrl;
`ifdef MULDIV_DIVREM_FUSE_EN
  localparam int FUSE_LAT = 2;
`else
  localparam int FUSE_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv_ctrl #(.MUL_LATENCY(2), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.mul_en = 1'b0; bus.mul_operation = 1'b0;
    bus.div_en = 1'b0; bus.div_operation = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_sel = '0;
    bus.flush = 1'b0; bus.wb_ready = 1'b0;
  endtask

  // Issue one request in the current cycle and wait (bounded) for result_valid.
  task automatic run(input string tag, input logic m, input logic mop, input logic d,
                     input logic dop, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, output int lat);
    int stall_low;
    stall_low = 0;
    bus.mul_en = m; bus.mul_operation = mop;
    bus.div_en = d; bus.div_operation = dop;
    bus.op_a = a; bus.op_b = b; bus.rd_sel = rd;
    #1;
    lat = 0;
    if (bus.stall !== 1'b1) stall_low++;
    while (lat < 60) begin
      step();
      lat++;
      bus.mul_en = 1'b0;
      bus.div_en = 1'b0;
      #1;
      if (bus.stall !== 1'b1) stall_low++;
      if (bus.result_valid === 1'b1) break;
    end
    check({tag, "_stall_busy"}, 32'(stall_low), 32'd0);
  endtask

  task automatic handshake(input string tag);
    bus.wb_ready = 1'b1;
    #1;
    check({tag, "_stall_hs"}, {31'd0, bus.stall}, 32'd0);
    step();
    bus.wb_ready = 1'b0;
    #1;
    check({tag, "_valid_drop"}, {31'd0, bus.result_valid}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic m, input logic mop, input logic d,
                       input logic dop, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    run(tag, m, mop, d, dop, a, b, rd, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_rd"}, {27'd0, bus.result_rd}, {27'd0, rd});
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int vcount;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", {27'd0, bus.result_rd}, 32'd0);
    check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
    rst_n = 1'b1;
    step();

    do_op("mul_7x-3", 1, 0, 0, 0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 3);
    do_op("mulh_min", 1, 1, 0, 0, 32'h80000000, 32'h80000000, 5'd17, 32'h40000000, 3);
    do_op("div_-7_2", 0, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 34);
    do_op("rem_-7_2", 0, 0, 1, 0, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, FUSE_LAT);
    do_op("div_7_-3", 0, 0, 1, 1, 32'd7, 32'hFFFFFFFD, 5'd6, 32'hFFFFFFFE, 34);
    do_op("rem_7_-3", 0, 0, 1, 0, 32'd7, 32'hFFFFFFFD, 5'd8, 32'd1, FUSE_LAT);
    do_op("div_100_7", 0, 0, 1, 1, 32'd100, 32'd7, 5'd10, 32'd14, 34);
    do_op("div_5_0", 0, 0, 1, 1, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, 2);
    do_op("rem_5_0", 0, 0, 1, 0, 32'd5, 32'd0, 5'd12, 32'd5, 2);
    do_op("div_ovf", 0, 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 2);
    do_op("rem_ovf", 0, 0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, 2);
    do_op("mul_wins", 1, 0, 1, 1, 32'd6, 32'd7, 5'd15, 32'd42, 3);

    // result held stable while writeback back-pressures
    run("hold", 1, 0, 0, 0, 32'h00012345, 32'h00000010, 5'd9, lat);
    check("hold_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_result", bus.result, 32'h00123450);
      check("hold_rd", {27'd0, bus.result_rd}, 32'd9);
      check("hold_valid", {31'd0, bus.result_valid}, 32'd1);
      check("hold_stall", {31'd0, bus.stall}, 32'd1);
    end
    handshake("hold");
    step();
    check("hold_idle_stall", {31'd0, bus.stall}, 32'd0);

    // flush wins over wb_ready in DONE
    run("done_flush", 1, 0, 0, 0, 32'd3, 32'd3, 5'd1, lat);
    check("done_flush_result", bus.result, 32'd9);
    bus.flush = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.wb_ready = 1'b0;
    #1;
    check("done_flush_valid", {31'd0, bus.result_valid}, 32'd0);
    check("done_flush_stall", {31'd0, bus.stall}, 32'd0);

    // flush in IDLE suppresses acceptance
    bus.mul_en = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd2; bus.flush = 1'b1;
    #1;
    check("idle_flush_stall", {31'd0, bus.stall}, 32'd0);
    step();
    clear_inputs();
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.result_valid !== 1'b0 || bus.stall !== 1'b0) vcount++;
    end
    check("idle_flush_quiet", 32'(vcount), 32'd0);

    // flush at T+10 of a DIV
    bus.div_en = 1'b1; bus.div_operation = 1'b1;
    bus.op_a = 32'hFFFFFFF9; bus.op_b = 32'd2; bus.rd_sel = 5'd2;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.div_en = 1'b0;
      if (bus.result_valid !== 1'b0) vcount++;
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    check("div_flush_stall", {31'd0, bus.stall}, 32'd0);
    check("div_flush_valid", {31'd0, bus.result_valid}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.result_valid !== 1'b0) vcount++;
    end
    check("div_flush_never_valid", 32'(vcount), 32'd0);
    do_op("div_after_flush", 0, 0, 1, 1, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 34);

    // asynchronous reset mid-MUL
    bus.mul_en = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.rd_sel = 5'd7;
    step();
    bus.mul_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_rd", {27'd0, bus.result_rd}, 32'd0);
    check("arst_valid", {31'd0, bus.result_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    do_op("mul_after_rst", 1, 0, 0, 0, 32'd5, 32'd5, 5'd7, 32'd25, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
